// File: rtl/mpeg_stream_monitor.sv
// Reference-vs-observed beat checker for the bhargava output stream, with status counters.
// Defining MON_TIMEOUT_EN adds a stall watchdog (parameter TIMEOUT) driving the timeout flag.
module mpeg_stream_monitor #(
  parameter int unsigned BYTES       = 1,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned PROG_MARGIN = 4,
  parameter int unsigned CNT_W       = 32,
  parameter bit          STOP_ON_ERR = 1'b1
`ifdef MON_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT     = 65535
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [8*BYTES-1:0] ref_data,
  input  logic               ref_en,
  output logic               ref_prog_full,
  input  logic               stream_end,
  input  logic [8*BYTES-1:0] obs_data,
  input  logic               obs_en,
  output logic [CNT_W-1:0]   in_cnt,
  output logic [CNT_W-1:0]   out_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   down_time,
  output logic               err,
  output logic [CNT_W-1:0]   err_idx,
  output logic [BYTES-1:0]   err_mask,
  output logic               overflow,
  output logic               underflow,
  output logic               timeout,
  output logic               done
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned DW      = 8 * BYTES;
  localparam int unsigned ProgLvl = DEPTH - PROG_MARGIN;

  localparam logic [AW:0]      FullOcc = DEPTH[AW:0];
  localparam logic [AW:0]      ProgThr = ProgLvl[AW:0];
  localparam logic [AW:0]      OccOne  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]    PtrOne  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StRun, StDrain, StHalt, StDone} state_e;

  state_e           state_q;
  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             end_seen_q;
  logic             prog_full_q, err_q, overflow_q, underflow_q;
  logic [CNT_W-1:0] in_cnt_q, out_cnt_q, err_cnt_q, down_time_q, err_idx_q;
  logic [BYTES-1:0] err_mask_q;

  logic             active, push, pop, under, err_now;
  logic [DW-1:0]    head;
  logic [BYTES-1:0] mask;

  always_comb begin
    active  = (state_q == StRun) || (state_q == StDrain);
    head    = mem[rd_ptr_q];
    pop     = clk_en && obs_en && active && (count_q != '0);
    under   = clk_en && obs_en && active && (count_q == '0);
    // A full FIFO still takes a beat when the head leaves in the same cycle.
    push    = clk_en && ref_en && (state_q != StDone) && ((count_q != FullOcc) || pop);
    mask    = '0;
    for (int i = 0; i < BYTES; i++) begin
      mask[i] = head[8*i +: 8] != obs_data[8*i +: 8];
    end
    err_now = under || (pop && (mask != '0));
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + OccOne;
    end else if (pop && !push) begin
      count_d = count_q - OccOne;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && push) begin
      mem[wr_ptr_q] <= ref_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      end_seen_q  <= 1'b0;
      prog_full_q <= 1'b0;
      err_q       <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      err_cnt_q   <= '0;
      down_time_q <= '0;
      err_idx_q   <= '0;
      err_mask_q  <= '0;
    end else if (clk_en) begin
      count_q     <= count_d;
      prog_full_q <= count_d >= ProgThr;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
        in_cnt_q <= in_cnt_q + CntOne;
      end
      if (ref_en && !push && (state_q != StDone)) begin
        overflow_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PtrOne;
        out_cnt_q <= out_cnt_q + CntOne;
      end
      if (under || (obs_en && (state_q == StDone))) begin
        underflow_q <= 1'b1;
      end
      if (err_now) begin
        err_cnt_q <= err_cnt_q + CntOne;
        if (!err_q) begin
          err_q      <= 1'b1;
          err_idx_q  <= out_cnt_q;
          err_mask_q <= under ? '1 : mask;
        end
      end
      if (prog_full_q && active) begin
        down_time_q <= down_time_q + CntOne;
      end
      if (stream_end) begin
        end_seen_q <= 1'b1;
      end
      case (state_q)
        StRun: begin
          if (STOP_ON_ERR && err_now) begin
            state_q <= StHalt;
          end else if (end_seen_q) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (STOP_ON_ERR && err_now) begin
            state_q <= StHalt;
          end else if ((count_d == '0) && !push) begin
            state_q <= StDone;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MON_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        timeout_q;

  // Watchdog only runs while beats sit in the FIFO with nothing being compared.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (clk_en) begin
      if (pop || (count_q == '0)) begin
        wd_q <= '0;
      end else if (active && (wd_q != TIMEOUT)) begin
        wd_q <= wd_q + 32'd1;
        if (wd_q + 32'd1 == TIMEOUT) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign ref_prog_full = prog_full_q;
  assign in_cnt        = in_cnt_q;
  assign out_cnt       = out_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign down_time     = down_time_q;
  assign err           = err_q;
  assign err_idx       = err_idx_q;
  assign err_mask      = err_mask_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_mpeg_stream_monitor.sv
// Directed bench for mpeg_stream_monitor: a continue-on-error instance (a) and a halt-on-error
// instance (b) share stimulus; a reference-beat queue supplies the expected compare results.
module tb_mpeg_stream_monitor;

  localparam int unsigned NB = 4;
`ifdef MON_TIMEOUT_EN
  localparam bit ExpTimeout = 1'b1;
`else
  localparam bit ExpTimeout = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
  logic        ref_en = 1'b0, obs_en = 1'b0, stream_end = 1'b0;
  logic [31:0] ref_data = '0, obs_data = '0;

  logic        pf_a, err_a, ovf_a, unf_a, to_a, done_a;
  logic [31:0] in_a, out_a, ecnt_a, dt_a, eidx_a;
  logic [3:0]  emask_a;
  logic        pf_b, err_b, ovf_b, unf_b, to_b, done_b;
  logic [31:0] in_b, out_b, ecnt_b, dt_b, eidx_b;
  logic [3:0]  emask_b;
  logic [11:0] any_a, any_b;

  int vectors = 0, fails = 0;
  logic [31:0] sb[$];
  logic [31:0] refs[0:99];
  int   a_out, a_ecnt, a_idx, b_out, b_ecnt, b_idx;
  logic a_err, b_err, b_halt;
  logic [3:0] a_mask, b_mask;

  mpeg_stream_monitor #(
    .BYTES(NB), .DEPTH(16), .PROG_MARGIN(4), .CNT_W(32), .STOP_ON_ERR(1'b0)
`ifdef MON_TIMEOUT_EN
    , .TIMEOUT(50)
`endif
  ) dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ref_data(ref_data), .ref_en(ref_en),
    .ref_prog_full(pf_a), .stream_end(stream_end), .obs_data(obs_data), .obs_en(obs_en),
    .in_cnt(in_a), .out_cnt(out_a), .err_cnt(ecnt_a), .down_time(dt_a), .err(err_a),
    .err_idx(eidx_a), .err_mask(emask_a), .overflow(ovf_a), .underflow(unf_a),
    .timeout(to_a), .done(done_a)
  );

  mpeg_stream_monitor #(
    .BYTES(NB), .DEPTH(16), .PROG_MARGIN(4), .CNT_W(32), .STOP_ON_ERR(1'b1)
`ifdef MON_TIMEOUT_EN
    , .TIMEOUT(50)
`endif
  ) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ref_data(ref_data), .ref_en(ref_en),
    .ref_prog_full(pf_b), .stream_end(stream_end), .obs_data(obs_data), .obs_en(obs_en),
    .in_cnt(in_b), .out_cnt(out_b), .err_cnt(ecnt_b), .down_time(dt_b), .err(err_b),
    .err_idx(eidx_b), .err_mask(emask_b), .overflow(ovf_b), .underflow(unf_b),
    .timeout(to_b), .done(done_b)
  );

  assign any_a = {pf_a, err_a, ovf_a, unf_a, to_a, done_a, |in_a, |out_a, |ecnt_a, |dt_a,
                  |eidx_a, |emask_a};
  assign any_b = {pf_b, err_b, ovf_b, unf_b, to_b, done_b, |in_b, |out_b, |ecnt_b, |dt_b,
                  |eidx_b, |emask_b};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mask_of(input logic [31:0] r, input logic [31:0] o);
    for (int i = 0; i < 4; i++) mask_of[i] = r[8*i +: 8] != o[8*i +: 8];
  endfunction

  task automatic do_reset();
    rst = 1'b1; clk_en = 1'b1; ref_en = 1'b0; obs_en = 1'b0; stream_end = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    a_out = 0; a_ecnt = 0; a_idx = 0; a_err = 1'b0; a_mask = '0;
    b_out = 0; b_ecnt = 0; b_idx = 0; b_err = 1'b0; b_mask = '0; b_halt = 1'b0;
  endtask

  // Expected effect of one observed beat compared against the queued reference head.
  task automatic model_obs(input logic [31:0] o);
    logic [31:0] r;
    logic [3:0]  m;
    r = sb.pop_front();
    m = mask_of(r, o);
    if (m != '0) begin
      a_ecnt++;
      if (!a_err) begin a_err = 1'b1; a_idx = a_out; a_mask = m; end
    end
    a_out++;
    if (!b_halt) begin
      if (m != '0) begin
        b_ecnt++; b_err = 1'b1; b_idx = b_out; b_mask = m; b_halt = 1'b1;
      end
      b_out++;
    end
  endtask

  task automatic run_stream(input int n, input int bad0, input int bad1, input int bad_byte,
                            input string tag);
    logic [31:0] o;
    do_reset();
    for (int i = 0; i < n; i++) refs[i] = $urandom;
    for (int c = 0; c < n + 6; c++) begin
      ref_en     = (c < n);
      ref_data   = (c < n) ? refs[c] : '0;
      stream_end = (c >= n);
      if (c < n) sb.push_back(refs[c]);
      obs_en = (c >= 5) && (c < n + 5);
      if (obs_en) begin
        o = refs[c-5];
        if ((c - 5 == bad0) || (c - 5 == bad1)) o = o ^ (32'hFF << (8 * bad_byte));
        obs_data = o;
        model_obs(o);
      end else begin
        obs_data = '0;
      end
      tick();
      check({tag, ".out_cnt_a"}, out_a, a_out);
      check({tag, ".out_cnt_b"}, out_b, b_out);
      check({tag, ".err_cnt_a"}, ecnt_a, a_ecnt);
      check({tag, ".done_a"}, 32'(done_a), 32'(c >= n + 4));
      check({tag, ".done_b"}, 32'(done_b), 32'(!b_halt && (c >= n + 4)));
    end
    ref_en = 1'b0; obs_en = 1'b0;
    check({tag, ".in_cnt_a"}, in_a, n);
    check({tag, ".in_cnt_b"}, in_b, n);
    check({tag, ".err_a"}, 32'(err_a), 32'(a_err));
    check({tag, ".err_idx_a"}, eidx_a, a_idx);
    check({tag, ".err_mask_a"}, 32'(emask_a), 32'(a_mask));
    check({tag, ".err_b"}, 32'(err_b), 32'(b_err));
    check({tag, ".err_idx_b"}, eidx_b, b_idx);
    check({tag, ".err_mask_b"}, 32'(emask_b), 32'(b_mask));
    check({tag, ".err_cnt_b"}, ecnt_b, b_ecnt);
  endtask

  initial begin
    int          occ, exp_in, dt, pops;
    logic        pf, ovf;
    logic [31:0] d;

    // Reset state
    do_reset();
    check("reset.a", 32'(any_a), 32'd0);
    check("reset.b", 32'(any_b), 32'd0);

    // Clean 100-beat echo, then single corruption, then two corruptions
    run_stream(100, -1, -1, 0, "clean100");
    check("clean100.err_a_const", 32'(err_a), 32'd0);
    run_stream(12, 7, -1, 2, "bad7");
    check("bad7.mask_b", 32'(emask_b), 32'h4);
    check("bad7.idx_b", eidx_b, 32'd7);
    check("bad7.out_b", out_b, 32'd8);
    run_stream(20, 3, 10, 1, "bad3_10");
    check("bad3_10.ecnt_a", ecnt_a, 32'd2);
    check("bad3_10.idx_a", eidx_a, 32'd3);

    // Fill past full with no observed beats
    do_reset();
    occ = 0; exp_in = 0; pf = 1'b0; ovf = 1'b0; dt = 0; pops = 0;
    for (int k = 0; k < 20; k++) begin
      d = $urandom; ref_en = 1'b1; ref_data = d;
      if (occ < 16) begin occ++; exp_in++; sb.push_back(d); end else ovf = 1'b1;
      if (pf) dt++;
      pf = (occ >= 12);
      tick();
      check("fill.prog_full", 32'(pf_a), 32'(pf));
      check("fill.overflow", 32'(ovf_a), 32'(ovf));
      check("fill.in_cnt", in_a, exp_in);
      check("fill.down_time", dt_a, dt);
    end
    check("fill.in_cnt_16", in_a, 32'd16);
    check("fill.overflow_b", 32'(ovf_b), 32'd1);

    // clk_en low freezes everything, even with both strobes high
    clk_en = 1'b0; obs_en = 1'b1; obs_data = '0;
    repeat (3) tick();
    check("hold.in_cnt", in_a, exp_in);
    check("hold.out_cnt", out_a, 32'd0);
    check("hold.down_time", dt_a, dt);
    clk_en = 1'b1; ref_en = 1'b0; obs_en = 1'b0;
    repeat (2) begin dt++; tick(); end
    check("idle.down_time", dt_a, dt);

    // Push and pop together while full
    d = $urandom; ref_en = 1'b1; ref_data = d; obs_en = 1'b1; obs_data = sb.pop_front();
    sb.push_back(d); exp_in++; pops++; dt++;
    tick();
    check("full_pp.in_cnt", in_a, exp_in);
    check("full_pp.out_cnt", out_a, pops);
    check("full_pp.prog_full", 32'(pf_a), 32'd1);
    check("full_pp.err_cnt", ecnt_a, 32'd0);

    // Drain below the threshold
    ref_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      obs_data = sb.pop_front(); occ--; pops++;
      if (pf) dt++;
      pf = (occ >= 12);
      tick();
      check("drain.prog_full", 32'(pf_a), 32'(pf));
      check("drain.down_time", dt_a, dt);
    end
    obs_en = 1'b0;
    check("drain.out_cnt", out_a, pops);

    // Underflow on empty FIFO, then reset mid-stream
    do_reset();
    obs_en = 1'b1; obs_data = $urandom;
    tick();
    obs_en = 1'b0;
    check("unf.underflow_a", 32'(unf_a), 32'd1);
    check("unf.err_a", 32'(err_a), 32'd1);
    check("unf.err_idx_a", eidx_a, 32'd0);
    check("unf.err_mask_a", 32'(emask_a), 32'hF);
    check("unf.err_cnt_a", ecnt_a, 32'd1);
    check("unf.out_cnt_a", out_a, 32'd0);
    check("unf.err_mask_b", 32'(emask_b), 32'hF);
    ref_en = 1'b1;
    repeat (3) begin ref_data = $urandom; tick(); end
    rst = 1'b1; obs_en = 1'b1;
    tick();
    check("midrst.a", 32'(any_a), 32'd0);
    check("midrst.b", 32'(any_b), 32'd0);
    rst = 1'b0; ref_en = 1'b0;
    tick();
    obs_en = 1'b0;
    check("midrst.emptied", 32'(unf_a), 32'd1);
    check("midrst.out_cnt", out_a, 32'd0);

    // Stalled FIFO for the watchdog
    do_reset();
    ref_en = 1'b1; ref_data = $urandom;
    tick();
    ref_en = 1'b0;
    repeat (40) tick();
    check("wd.early_a", 32'(to_a), 32'd0);
    repeat (20) tick();
    check("wd.late_a", 32'(to_a), 32'(ExpTimeout));
    check("wd.late_b", 32'(to_b), 32'(ExpTimeout));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/mpeg_stream_monitor.md
Name: mpeg_stream_monitor

Overview:
- Synthesizable, parametrised successor to the byte-level loopback checking done around the bhargava core.
- Buffers a reference stream, compares it beat-by-beat against the core's output stream, and reports status.
- Status: counts, first-mismatch position, per-byte mismatch mask, backpressure downtime, completion.
- Sits beside bhargava on-chip: reference feed in, mpeg_out/mpeg_out_en in, status to host registers.

Parameters:
BYTES, 1, bytes per beat; data ports are 8*BYTES wide
DEPTH, 64, reference FIFO depth in beats (power of two, >=8)
PROG_MARGIN, 4, ref_prog_full asserts when occupancy >= DEPTH-PROG_MARGIN
CNT_W, 32, width of all counters
STOP_ON_ERR, 1, 1: freeze comparison after first error; 0: keep comparing, count errors

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clk_en  in  1  global qualifier; no state changes when 0
ref_data  in  8*BYTES  reference beat, byte 0 in bits [7:0]
ref_en  in  1  reference beat valid
ref_prog_full  out  1  registered programmable-full backpressure to the reference source
stream_end  in  1  level; reference source has delivered its last beat
obs_data  in  8*BYTES  observed beat from the core
obs_en  in  1  observed beat valid (no backpressure on this side)
in_cnt  out  CNT_W  reference beats accepted
out_cnt  out  CNT_W  observed beats compared
err_cnt  out  CNT_W  mismatching beats
down_time  out  CNT_W  clk_en cycles with ref_prog_full=1 before done
err  out  1  sticky: first error seen
err_idx  out  CNT_W  out_cnt value of the first erroneous beat
err_mask  out  BYTES  per-byte mismatch mask of the first erroneous beat
overflow  out  1  sticky: ref_en while FIFO full and no pop
underflow  out  1  sticky: obs_en while FIFO empty
timeout  out  1  sticky watchdog flag (see Optional Feature)
done  out  1  stream fully checked

Behaviour:
- Reset: all outputs 0; FIFO emptied; end_seen cleared; state RUN. Reset mid-stream discards all contents in the same cycle.
- All updates require clk_en=1. With clk_en=0, ref_en and obs_en are ignored.
- Push on ref_en when occupancy<DEPTH, or when occupancy=DEPTH and a pop occurs in the same cycle. Otherwise the beat is dropped and overflow is set. in_cnt counts accepted beats only.
- Push and pop in the same cycle leave occupancy unchanged.
- ref_prog_full is registered from next-cycle occupancy >= DEPTH-PROG_MARGIN and deasserts as soon as that condition is false.
- Compare on obs_en with FIFO non-empty:
  - pop head; mask[i] = head byte i != obs byte i; out_cnt+1.
  - if mask!=0: err_cnt+1; if err=0, set err, err_idx=pre-increment out_cnt, err_mask=mask.
  - Results are visible the cycle after the obs beat (latency 1).
- obs_en with FIFO empty: set underflow, no pop, out_cnt unchanged. Treated as an error: err_cnt+1; if first error, err_idx=out_cnt and err_mask=all ones.
- end_seen latches on stream_end=1 and stays set until rst.
- States:
  - RUN -> DRAIN when end_seen.
  - RUN/DRAIN -> HALT on first error if STOP_ON_ERR=1. HALT ignores obs_en (no pops, no counts) but still accepts pushes.
  - DRAIN -> DONE when occupancy=0 and no push pending.
  - DONE: done=1, counters frozen. A later obs_en sets underflow only.
  - HALT and DONE are left only by rst.
- down_time increments when clk_en=1, ref_prog_full=1 and state is not DONE or HALT.
- Counters wrap modulo 2^CNT_W silently.

Optional Feature:
- MON_TIMEOUT_EN defined:
  - Adds parameter TIMEOUT (default 65535) and a watchdog counter.
  - Watchdog clears on a compare beat or when the FIFO is empty; otherwise increments in RUN/DRAIN.
  - On reaching TIMEOUT, sets sticky timeout.
- Not defined: no watchdog logic; timeout tied to 0; port list unchanged.

Test Plan:
- BYTES=1, push 100 bytes 0..99 and stream_end, echo the same bytes on obs after 5 cycles -> out_cnt=100, err=0, done=1 one cycle after last pop.
- BYTES=4, beat 7 byte 2 corrupted, STOP_ON_ERR=1 -> err=1, err_idx=7, err_mask=4'b0100, out_cnt stays 8, state HALT.
- STOP_ON_ERR=0, corrupt beats 3 and 10 of 20 -> err_cnt=2, err_idx=3, out_cnt=20, done=1.
- DEPTH=16, PROG_MARGIN=4, 20 pushes with no obs -> ref_prog_full=1 from occupancy 12; the 17th push sets overflow; in_cnt=16; down_time increments each cycle while full.
- obs_en with empty FIFO -> underflow=1, err_idx=0, err_mask all ones; then rst mid-stream -> all outputs 0 next cycle.
- MON_TIMEOUT_EN, TIMEOUT=50, 1 beat pushed and no obs for 60 cycles -> timeout=1 after 50 cycles. Undefined -> timeout stays 0.
